// File: rtl/pipeline_stage_elastic.sv
// Elastic valid/ready register chain of DEPTH skid-buffered stages with flush and occupancy.
// Optional PIPE_STALL_CNT_EN adds a saturating count of cycles where input was blocked.
module pipeline_stage_elastic #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);

  logic [WIDTH-1:0] main_q [DEPTH];
  logic [WIDTH-1:0] main_d [DEPTH];
  logic [WIDTH-1:0] skid_q [DEPTH];
  logic [WIDTH-1:0] skid_d [DEPTH];
  logic [DEPTH-1:0] main_vld_q, main_vld_d;
  logic [DEPTH-1:0] skid_vld_q, skid_vld_d;

  logic             up_vld  [DEPTH];
  logic [WIDTH-1:0] up_data [DEPTH];
  logic             dn_rdy  [DEPTH];
  logic             up_acc  [DEPTH];

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_fire, out_fire;

  // Stage k is fed by stage k-1's main register and backpressured by stage k+1's skid.
  for (genvar k = 0; k < DEPTH; k++) begin : g_link
    if (k == 0) begin : g_head
      assign up_vld[k]  = in_valid;
      assign up_data[k] = in_data;
    end else begin : g_mid
      assign up_vld[k]  = main_vld_q[k-1];
      assign up_data[k] = main_q[k-1];
    end
    if (k == DEPTH-1) begin : g_tail
      assign dn_rdy[k] = out_ready;
    end else begin : g_body
      assign dn_rdy[k] = ~skid_vld_q[k+1];
    end
    assign up_acc[k] = up_vld[k] & ~skid_vld_q[k];
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      main_d[k]     = main_q[k];
      skid_d[k]     = skid_q[k];
      main_vld_d[k] = main_vld_q[k];
      skid_vld_d[k] = skid_vld_q[k];
      if (!main_vld_q[k] || dn_rdy[k]) begin
        // Skid can only be full while main is full, and then upstream is not accepted.
        if (skid_vld_q[k]) begin
          main_d[k]     = skid_q[k];
          main_vld_d[k] = 1'b1;
          skid_vld_d[k] = 1'b0;
        end else if (up_acc[k]) begin
          main_d[k]     = up_data[k];
          main_vld_d[k] = 1'b1;
        end else begin
          main_vld_d[k] = 1'b0;
        end
      end else if (up_acc[k]) begin
        skid_d[k]     = up_data[k];
        skid_vld_d[k] = 1'b1;
      end
    end
  end

  assign in_ready  = ~skid_vld_q[0] & reset & ~flush;
  assign out_valid = main_vld_q[DEPTH-1] & reset & ~flush;
  assign out_data  = main_q[DEPTH-1];
  assign occupancy = occ_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign occ_d    = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_vld_q <= '0;
      skid_vld_q <= '0;
      occ_q      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        main_q[k] <= '0;
        skid_q[k] <= '0;
      end
    end else if (flush) begin
      main_vld_q <= '0;
      skid_vld_q <= '0;
      occ_q      <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      occ_q      <= occ_d;
      for (int k = 0; k < DEPTH; k++) begin
        main_q[k] <= main_d[k];
        skid_q[k] <= skid_d[k];
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && !flush && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`endif

endmodule
